// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Frame FSM states, queue entry layout and error bit positions.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   typedef struct packed {
      logic [1:0] err;
      logic [7:0] data;
   } ps2_entry_t;

   localparam int PS2_ERR_PARITY = 0;
   localparam int PS2_ERR_STOP   = 1;

   // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_err(input logic [7:0] i_data, input logic i_par);
      return ~(^i_data ^ i_par);
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Flop-based synchronous FIFO with show-ahead read port.
// A push into a full queue is accepted only if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_valid,
   output logic             o_full,
   output logic             o_overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_valid;
   logic             r_full;
   logic             r_overflow;

   logic             w_pop;
   logic             w_push;
   logic [CW-1:0]    w_count_nxt;

   assign w_pop       = i_rd_en & r_valid;
   assign w_push      = i_wr_en & (~r_full | w_pop);
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_valid    <= 1'b0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count    <= w_count_nxt;
         r_valid    <= (w_count_nxt != '0);
         r_full     <= (w_count_nxt == CW'(DEPTH));
         r_overflow <= i_wr_en & r_full & ~w_pop;
      end
   end

   // Storage carries no reset; the head is masked while the queue is empty.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data  = r_valid ? r_mem[r_rd_ptr] : '0;
   assign o_valid    = r_valid;
   assign o_full     = r_full;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered clock, frame FSM
// with parity/stop checking and inter-bit timeout, feeding a show-ahead byte queue.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_PS2_IN,
   input  logic       DATA_PS2_IN,
   input  logic       RX_ENABLE,
   input  logic       RD_EN,
   output logic [7:0] DOUT,
   output logic [1:0] DERR,
   output logic       DVALID,
   output logic       FULL,
   output logic       OVERFLOW,
   output logic       TIMEOUT
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          r_clk_s1, r_clk_s2;
   logic          r_dat_s1, r_dat_s2;
   logic          r_filt, r_filt_d;
   logic [FW-1:0] r_fcnt;
   logic [TW-1:0] r_to_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_par;
   ps2_state_t    r_state;

   ps2_state_t    w_state_nxt;
   logic          w_strobe;
   logic          w_to_hit;
   logic          w_push;
   logic          w_timeout;
   ps2_entry_t    w_entry;
   ps2_entry_t    w_head;
   logic [9:0]    w_rd_data;

   // Pin synchronisers and clock filter: the filter only follows a level held FILTER_LEN samples.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
         r_filt   <= 1'b1;
         r_filt_d <= 1'b1;
         r_fcnt   <= '0;
      end else begin
         r_clk_s1 <= CLK_PS2_IN;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= DATA_PS2_IN;
         r_dat_s2 <= r_dat_s1;
         r_filt_d <= r_filt;
         if (r_clk_s2 == r_filt) begin
            r_fcnt <= '0;
         end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
            r_filt <= r_clk_s2;
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + FW'(1);
         end
      end
   end

   assign w_strobe = r_filt_d & ~r_filt;
   assign w_to_hit = (r_state != IDLE) & RX_ENABLE & ~w_strobe &
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state   <= IDLE;
         r_to_cnt  <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == IDLE) || w_strobe || !RX_ENABLE) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + TW'(1);
         end
         if (w_strobe) begin
            if (r_state == IDLE)      r_bit_cnt <= '0;
            else if (r_state == DATA) r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_strobe) begin
         if (r_state == DATA)   r_shift <= {r_dat_s2, r_shift[7:1]};
         if (r_state == PARITY) r_par   <= r_dat_s2;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_timeout   = 1'b0;
      if (!RX_ENABLE) begin
         w_state_nxt = IDLE;
      end else if (w_to_hit) begin
         w_state_nxt = IDLE;
         w_timeout   = 1'b1;
      end else if (w_strobe) begin
         case (r_state)
            IDLE:    if (!r_dat_s2) w_state_nxt = DATA;
            DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
            PARITY:  w_state_nxt = STOP;
            STOP: begin
               w_state_nxt = IDLE;
               w_push      = 1'b1;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // The stop bit is taken straight from the pin in the push cycle.
   always_comb begin
      w_entry.data                 = r_shift;
      w_entry.err[PS2_ERR_PARITY]  = odd_parity_err(r_shift, r_par);
      w_entry.err[PS2_ERR_STOP]    = ~r_dat_s2;
   end

   sync_fifo #(
      .WIDTH($bits(ps2_entry_t)),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_wr_en   (w_push),
      .i_wr_data (w_entry),
      .i_rd_en   (RD_EN),
      .o_rd_data (w_rd_data),
      .o_valid   (DVALID),
      .o_full    (FULL),
      .o_overflow(OVERFLOW)
   );

   assign w_head  = w_rd_data;
   assign DOUT    = w_head.data;
   assign DERR    = w_head.err;
   assign TIMEOUT = w_timeout;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: table of frames, corner-case sequences and a random
// run checked against a queue model of received frames.
module tb_ps2_rx_fifo;

   localparam int F = 4;
   localparam int T = 200;
   localparam int D = 4;
   localparam int H = 20;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       CLK_PS2_IN = 1'b1;
   logic       DATA_PS2_IN = 1'b1;
   logic       RX_ENABLE = 1'b0;
   logic       RD_EN = 1'b0;
   logic [7:0] DOUT;
   logic [1:0] DERR;
   logic       DVALID, FULL, OVERFLOW, TIMEOUT;

   ps2_rx_fifo #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
      .CLK(CLK), .RESET(RESET), .CLK_PS2_IN(CLK_PS2_IN), .DATA_PS2_IN(DATA_PS2_IN),
      .RX_ENABLE(RX_ENABLE), .RD_EN(RD_EN), .DOUT(DOUT), .DERR(DERR),
      .DVALID(DVALID), .FULL(FULL), .OVERFLOW(OVERFLOW), .TIMEOUT(TIMEOUT)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   int ovf_cnt = 0, ovf_cyc = -1;
   int to_cnt = 0, to_cyc = -1;
   int dv_rise_cyc = -1;
   logic dv_prev = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      dv_prev <= DVALID;
      if (DVALID && !dv_prev) dv_rise_cyc <= cyc;
      if (OVERFLOW) begin
         ovf_cnt <= ovf_cnt + 1;
         ovf_cyc <= cyc;
      end
      if (TIMEOUT) begin
         to_cnt <= to_cnt + 1;
         to_cyc <= cyc;
      end
   end

   int n_chk = 0, n_pass = 0;
   int last_fall = 0;
   logic [9:0] mq[$];

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      logic [1:0] err;
   } vec_t;

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [9:0] model_frame(input logic [7:0] d, input logic p, input logic s);
      logic pe, se;
      pe = ((($countones(d) + int'(p)) % 2) == 0);
      se = !s;
      return {se, pe, d};
   endfunction

   function automatic logic odd_bit(input logic [7:0] d);
      return ($countones(d) % 2) == 0;
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
      for (int i = 0; i < nbits; i++) begin
         DATA_PS2_IN = bits[i];
         if (i == glitch_bit) begin
            step(H / 2);
            CLK_PS2_IN = 1'b0;
            step(2);
            CLK_PS2_IN = 1'b1;
            step(H - H / 2 - 2);
         end else begin
            step(H);
         end
         CLK_PS2_IN = 1'b0;
         last_fall = cyc;
         step(H);
         CLK_PS2_IN = 1'b1;
      end
      DATA_PS2_IN = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int glitch_bit);
      send_bits({s, p, d, 1'b0}, 11, glitch_bit);
      step(H);
      if (mq.size() < D) mq.push_back(model_frame(d, p, s));
   endtask

   task automatic pop_chk(input string nm);
      if (mq.size() == 0) begin
         chk({nm, "_empty_dvalid"}, int'(DVALID), 0);
      end else begin
         chk({nm, "_dvalid"}, int'(DVALID), 1);
         chk({nm, "_entry"}, int'({DERR, DOUT}), int'(mq[0]));
         RD_EN = 1'b1;
         step(1);
         RD_EN = 1'b0;
         void'(mq.pop_front());
      end
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_dout"}, int'(DOUT), 0);
      chk({nm, "_derr"}, int'(DERR), 0);
      chk({nm, "_dvalid"}, int'(DVALID), 0);
      chk({nm, "_full"}, int'(FULL), 0);
      chk({nm, "_ovf"}, int'(OVERFLOW), 0);
      chk({nm, "_to"}, int'(TIMEOUT), 0);
   endtask

   initial begin
      vec_t vecs[6];
      int   t0, o0, npop;
      logic [7:0] d;
      logic p, s, was_full;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 2'b00};
      vecs[1] = '{8'hA5, 1'b0, 1'b1, 2'b01};
      vecs[2] = '{8'h3C, 1'b1, 1'b0, 2'b10};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 2'b00};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 2'b00};
      vecs[5] = '{8'h80, 1'b1, 1'b0, 2'b11};

      step(1);
      RESET = 1'b0;
      step(3);
      chk_reset_outs("reset");
      RESET = 1'b1;
      RX_ENABLE = 1'b1;
      step(5);

      // Table of single frames: latency, byte, error bits, pop
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, -1);
         chk("tbl_latency", dv_rise_cyc, last_fall + F + 3);
         chk("tbl_dout", int'(DOUT), int'(vecs[i].d));
         chk("tbl_derr", int'(DERR), int'(vecs[i].err));
         pop_chk("tbl_pop");
         chk("tbl_after_pop_dvalid", int'(DVALID), 0);
      end

      // Glitches in idle and mid-frame
      CLK_PS2_IN = 1'b0;
      step(2);
      CLK_PS2_IN = 1'b1;
      step(H);
      chk("glitch_idle_dvalid", int'(DVALID), 0);
      send_frame(8'h5A, 1'b1, 1'b1, 5);
      chk("glitch_dout", int'(DOUT), 8'h5A);
      chk("glitch_derr", int'(DERR), 0);
      pop_chk("glitch_pop");
      chk("glitch_single_entry", int'(DVALID), 0);

      // Timeout after start + 3 data bits
      t0 = to_cnt;
      send_bits({1'b1, 1'b1, 8'h12, 1'b0}, 4, -1);
      step(T);
      chk("timeout_pulses", to_cnt - t0, 1);
      chk("timeout_cycle", to_cyc, last_fall + F + 2 + T);
      chk("timeout_no_entry", int'(DVALID), 0);
      send_frame(8'h12, odd_bit(8'h12), 1'b1, -1);
      pop_chk("timeout_next");
      chk("timeout_next_empty", int'(DVALID), 0);

      // Fill the queue, then overflow
      o0 = ovf_cnt;
      for (int v = 1; v <= 5; v++) begin
         if (v == 5) chk("ovf_none_before", ovf_cnt - o0, 0);
         send_frame(8'(v), odd_bit(8'(v)), 1'b1, -1);
         if (v == 4) chk("full_after_4", int'(FULL), 1);
      end
      chk("ovf_pulses", ovf_cnt - o0, 1);
      chk("ovf_cycle", ovf_cyc, last_fall + F + 3);
      chk("full_after_5", int'(FULL), 1);
      chk("head_is_01", int'(DOUT), 8'h01);

      // Push into a full queue with a pop in the same cycle
      o0 = ovf_cnt;
      send_bits({1'b1, odd_bit(8'h06), 8'h06, 1'b0}, 10, -1);
      DATA_PS2_IN = 1'b1;
      step(H);
      CLK_PS2_IN = 1'b0;
      last_fall = cyc;
      step(F + 2);
      RD_EN = 1'b1;
      step(1);
      RD_EN = 1'b0;
      step(H - F - 3);
      CLK_PS2_IN = 1'b1;
      step(H);
      void'(mq.pop_front());
      mq.push_back(model_frame(8'h06, odd_bit(8'h06), 1'b1));
      chk("pushpop_no_ovf", ovf_cnt - o0, 0);
      chk("pushpop_full", int'(FULL), 1);
      for (int k = 0; k < 4; k++) pop_chk("fill_drain");
      chk("fill_drained", int'(DVALID), 0);

      // RX_ENABLE dropped mid-frame
      t0 = to_cnt;
      send_bits({1'b1, 1'b0, 8'hC3, 1'b0}, 5, -1);
      RX_ENABLE = 1'b0;
      step(5);
      RX_ENABLE = 1'b1;
      step(T + 20);
      chk("dis_no_timeout", to_cnt - t0, 0);
      chk("dis_no_entry", int'(DVALID), 0);
      send_frame(8'h77, odd_bit(8'h77), 1'b1, -1);
      pop_chk("dis_next");
      chk("dis_only_one", int'(DVALID), 0);

      // Reset mid-frame with a non-empty queue
      send_frame(8'h33, odd_bit(8'h33), 1'b1, -1);
      send_bits({1'b1, 1'b0, 8'hF0, 1'b0}, 6, -1);
      RESET = 1'b0;
      step(1);
      chk_reset_outs("midreset");
      step(2);
      RESET = 1'b1;
      mq.delete();
      step(5);
      send_frame(8'h42, odd_bit(8'h42), 1'b1, -1);
      pop_chk("reset_next");
      chk("reset_next_empty", int'(DVALID), 0);

      // Random frames with random reads
      for (int r = 0; r < 24; r++) begin
         d = 8'($urandom);
         p = odd_bit(d) ^ ($urandom_range(0, 3) == 0);
         s = ($urandom_range(0, 4) != 0);
         o0 = ovf_cnt;
         was_full = (mq.size() == D);
         send_frame(d, p, s, -1);
         chk("rnd_ovf", ovf_cnt - o0, was_full ? 1 : 0);
         chk("rnd_dvalid", int'(DVALID), (mq.size() != 0) ? 1 : 0);
         chk("rnd_full", int'(FULL), (mq.size() == D) ? 1 : 0);
         npop = $urandom_range(0, 2);
         for (int k = 0; k < npop; k++) pop_chk("rnd_pop");
      end
      while (mq.size() > 0) pop_chk("rnd_drain");
      chk("rnd_end_empty", int'(DVALID), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
